input_conditioner: RTL and testbench



---
 rtl/input_conditioner.sv | 109 ++++++++++
 tb/tb_input_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Conditions the raw board inputs (10 switches, 4 push buttons) for the
//   MMIO read path. Every bit passes through a 2-flop synchronizer and a
//   consecutive-cycle debounce filter. Each button also has a sticky
//   press-event flag that software clears through a masked clear strobe.
//
// Ports:
//   clk           in   1   free-running system clock (ignores core clk_en)
//   async_rst     in   1   asynchronous, active-low reset of every flop
//   raw_switches  in  10   unsynchronized switch pins
//   raw_buttons   in   4   unsynchronized push-button pins, active-high
//   clr_valid     in   1   one-cycle clear strobe from the MMIO write decode
//   clr_mask      in   4   bit i=1 clears press_event[i] when clr_valid=1
//   switches      out 10   debounced switch levels
//   buttons       out  4   debounced button levels
//   press_event   out  4   sticky flag per button, set on a debounced 0->1
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       async_rst,
    input  logic [9:0] raw_switches,
    input  logic [3:0] raw_buttons,
    input  logic       clr_valid,
    input  logic [3:0] clr_mask,
    output logic [9:0] switches,
    output logic [3:0] buttons,
    output logic [3:0] press_event
);

    localparam int             NB      = 14;
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Buttons occupy the top four bits so the press logic can slice them off.
    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_s0;
    logic [NB-1:0] r_s1;
    logic [NB-1:0] r_stable;
    logic [NB-1:0] w_stable_nxt;
    logic [CW-1:0] r_cnt     [NB];
    logic [CW-1:0] w_cnt_nxt [NB];
    logic [3:0]    r_press;
    logic [3:0]    w_press_nxt;
    logic [3:0]    w_rise;
    logic [3:0]    w_clr;

    assign w_raw = {raw_buttons, raw_switches};

    // Debounce rule: any agreement between s1 and the stable value restarts
    // the count; only DEBOUNCE_CYCLES consecutive disagreements flip it.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the block leaves one unassigned and a latch is never inferred.
        w_stable_nxt = r_stable;
        for (int i = 0; i < NB; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_s1[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_nxt[i] = r_s1[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // The rise is taken from the next-state value so the flag sets on the
    // same edge the debounced button goes high. Set is ORed in after the
    // clear, which makes a simultaneous set win.
    always_comb begin
        w_rise      = w_stable_nxt[NB-1 -: 4] & ~r_stable[NB-1 -: 4];
        w_clr       = clr_valid ? clr_mask : 4'b0000;
        w_press_nxt = (r_press & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_s0     <= '0;
            r_s1     <= '0;
            r_stable <= '0;
            r_press  <= '0;
            // NOTE: the counter array is ordinary flops, not RAM, so it is
            // cleared with the rest; a reset therefore discards partial counts.
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make s1 take the old s0, giving a
            // true two-stage synchronizer rather than a single flop.
            r_s0     <= w_raw;
            r_s1     <= r_s0;
            r_stable <= w_stable_nxt;
            r_press  <= w_press_nxt;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign switches    = r_stable[9:0];
    assign buttons     = r_stable[NB-1 -: 4];
    assign press_event = r_press;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4. A
// behavioural model tracks the synchronizer delay and a window of the last
// DEBOUNCE_CYCLES synchronized samples: a bit flips only when the whole
// window disagrees with its stable value. Directed scenarios are followed
// by a randomized phase.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       async_rst;
    logic [9:0] raw_switches;
    logic [3:0] raw_buttons;
    logic       clr_valid;
    logic [3:0] clr_mask;
    logic [9:0] switches;
    logic [3:0] buttons;
    logic [3:0] press_event;

    int n_tests = 0;
    int n_fail  = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .async_rst    (async_rst),
        .raw_switches (raw_switches),
        .raw_buttons  (raw_buttons),
        .clr_valid    (clr_valid),
        .clr_mask     (clr_mask),
        .switches     (switches),
        .buttons      (buttons),
        .press_event  (press_event)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [13:0] m_s0, m_s1, m_stable;
    logic [3:0]  m_pe;
    logic [13:0] m_win[$];

    task automatic model_reset();
        m_s0     = '0;
        m_s1     = '0;
        m_stable = '0;
        m_pe     = '0;
        m_win    = {};
        repeat (D) m_win.push_back(14'h0);
    endtask

    task automatic model_edge(input logic [13:0] raw, input logic cv, input logic [3:0] cm);
        logic [13:0] flip;
        logic [13:0] nxt;
        logic [3:0]  rise;
        m_win.push_back(m_s1);
        void'(m_win.pop_front());
        flip = '1;
        foreach (m_win[j]) flip &= (m_win[j] ^ m_stable);
        nxt  = m_stable ^ flip;
        rise = nxt[13:10] & ~m_stable[13:10];
        m_pe = (m_pe & ~(cv ? cm : 4'h0)) | rise;
        m_stable = nxt;
        m_s1 = m_s0;
        m_s0 = raw;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("switches",    16'(switches),    16'(m_stable[9:0]));
        check("buttons",     16'(buttons),     16'(m_stable[13:10]));
        check("press_event", 16'(press_event), 16'(m_pe));
    endtask

    // One clock edge: update the model with the inputs held at that edge,
    // sample 1 time unit later, then drop the clear strobe.
    task automatic step();
        @(posedge clk);
        model_edge({raw_buttons, raw_switches}, clr_valid, clr_mask);
        #1;
        check_all();
        clr_valid = 1'b0;
        clr_mask  = 4'h0;
    endtask

    // Assert reset away from the edge, verify outputs clear without a clock,
    // release on the falling edge.
    task automatic do_reset();
        async_rst = 1'b0;
        #1;
        model_reset();
        check("rst_switches", 16'(switches),    16'h0);
        check("rst_buttons",  16'(buttons),     16'h0);
        check("rst_press",    16'(press_event), 16'h0);
        @(negedge clk);
        async_rst = 1'b1;
    endtask

    initial begin
        logic seen;
        logic [13:0] flipm;

        // Reset values with all raw inputs high and no clock edge yet.
        async_rst    = 1'b0;
        raw_switches = 10'h3FF;
        raw_buttons  = 4'hF;
        clr_valid    = 1'b0;
        clr_mask     = 4'h0;
        model_reset();
        #2;
        check("init_switches", 16'(switches),    16'h0);
        check("init_buttons",  16'(buttons),     16'h0);
        check("init_press",    16'(press_event), 16'h0);
        raw_switches = '0;
        raw_buttons  = '0;
        @(negedge clk);
        async_rst = 1'b1;

        // Clean latency: visible after edge 5, still 0 after edge 4.
        raw_switches = 10'h201;
        for (int e = 0; e <= 5; e++) begin
            step();
            if (e == 4) check("lat_edge4", 16'(switches), 16'h0);
            if (e == 5) check("lat_edge5", 16'(switches), 16'h201);
        end
        repeat (3) step();

        // Glitch of 3 cycles is rejected.
        raw_buttons = 4'b0100;
        repeat (3) step();
        raw_buttons = 4'b0000;
        repeat (8) step();
        check("glitch3_buttons", 16'(buttons),     16'h0);
        check("glitch3_press",   16'(press_event), 16'h0);

        // 4-cycle pulse qualifies and leaves a sticky flag.
        raw_buttons = 4'b0100;
        repeat (4) step();
        raw_buttons = 4'b0000;
        seen = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            if (buttons[2]) seen = 1'b1;
        end
        check("pulse4_seen",    16'(seen),           16'h1);
        check("pulse4_buttons", 16'(buttons),        16'h0);
        check("pulse4_press",   16'(press_event[2]), 16'h1);

        // Masked clear and set/clear collision.
        raw_buttons = 4'hF;
        repeat (8) step();
        raw_buttons = 4'h0;
        repeat (8) step();
        check("clr_pre", 16'(press_event), 16'hF);
        clr_valid = 1'b1;
        clr_mask  = 4'b0101;
        step();
        check("clr_0101", 16'(press_event), 16'b1010);
        clr_valid = 1'b1;
        clr_mask  = 4'b0010;
        step();
        check("clr_0010", 16'(press_event), 16'b1000);
        raw_buttons = 4'b0010;
        repeat (5) step();
        clr_valid = 1'b1;
        clr_mask  = 4'b0010;
        step();
        check("collide_btn",   16'(buttons[1]),     16'h1);
        check("collide_press", 16'(press_event[1]), 16'h1);
        raw_buttons = 4'h0;
        repeat (8) step();

        // Restart on bounce: high 3, low 1, high again; rise at run start + 5.
        raw_buttons[0] = 1'b1;
        repeat (3) step();
        raw_buttons[0] = 1'b0;
        step();
        raw_buttons[0] = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            check("bounce_btn0", 16'(buttons[0]), 16'((e == 5) ? 1 : 0));
        end
        raw_buttons = 4'h0;
        repeat (8) step();

        // Reset mid-count: partial count is lost, full latency after release.
        raw_switches = 10'h008;
        repeat (3) step();
        do_reset();
        for (int e = 0; e <= 5; e++) begin
            step();
            check("rstmid_sw3", 16'(switches[3]), 16'((e == 5) ? 1 : 0));
        end

        // Randomized phase against the model.
        for (int n = 0; n < 600; n++) begin
            flipm = 14'($urandom) & 14'($urandom) & 14'($urandom);
            {raw_buttons, raw_switches} = {raw_buttons, raw_switches} ^ flipm;
            if ($urandom_range(5) == 0) begin
                clr_valid = 1'b1;
                clr_mask  = 4'($urandom);
            end
            step();
            if ($urandom_range(199) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
